awg_cmd_ctrl: RTL and testbench

- Control-plane block between the UART receiver and the DDS waveform datapath.
- Parses framed ASCII commands that set waveform select, frequency, amplitude and phase offset, with syntax and range checks.
- Holds new settings in shadow registers and commits them atomically to the live outputs, either at the next DDS phase-accumulator wrap or immediately.
- Replaces free-running digit shifting with a validated, glitch-free configuration path.

---
 rtl/awg_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_awg_cmd_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/awg_cmd_ctrl.sv
// awg_cmd_ctrl: parses framed ASCII set-commands ("S<field><digits>;") coming
// from the UART receiver, validates syntax and range, stages the value in a
// shadow register and commits all shadows atomically to the live DDS
// configuration, either on the next phase-accumulator wrap or immediately.
module awg_cmd_ctrl #(
  parameter int unsigned WAVE_NUM   = 5,
  parameter int unsigned FREQ_MAX   = 4095,
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter bit          SYNC_APPLY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        phase_wrap,
  output logic [2:0]  wave_sel,
  output logic [11:0] freq_word,
  output logic [3:0]  amp,
  output logic [7:0]  phase_off,
  output logic        cfg_update,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned DW = $clog2(MAX_DIGITS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DIG_MAX = DW'(MAX_DIGITS);

  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_A    = 8'h41;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_SEMI = 8'h3B;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  localparam logic [1:0] E_SYNTAX  = 2'd0;
  localparam logic [1:0] E_RANGE   = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_BUSY    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIELD,
    S_DIGITS,
    S_PENDING,
    S_APPLY
  } state_t;

  typedef enum logic [1:0] {
    F_W,
    F_F,
    F_A,
    F_P
  } field_t;

  state_t          state, state_nxt;
  field_t          field, field_nxt;
  logic [13:0]     acc, acc_nxt, acc_dig, field_max;
  logic [DW-1:0]   cnt, cnt_nxt;
  logic [TW-1:0]   tmo, tmo_nxt;
  logic            err_nxt;
  logic [1:0]      code_nxt;
  logic            commit, sh_wr;
  logic            is_digit;

  logic [2:0]      sh_wave;
  logic [11:0]     sh_freq;
  logic [3:0]      sh_amp;
  logic [7:0]      sh_phase;

  assign is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
  // The digit-count check rejects a digit before this product could exceed 14 bits.
  assign acc_dig  = acc * 14'd10 + {10'd0, rx_data[3:0]};
  assign busy     = (state == S_PENDING);

  // Upper bound for the value of the field being parsed.
  always_comb begin
    field_max = '0;
    case (field)
      F_W:     field_max = 14'(WAVE_NUM - 1);
      F_F:     field_max = 14'(FREQ_MAX);
      F_A:     field_max = 14'd15;
      F_P:     field_max = 14'd255;
      default: field_max = '0;
    endcase
  end

  // Frame parser: next state, accumulator, timeout and error decisions.
  always_comb begin
    state_nxt = state;
    field_nxt = field;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    tmo_nxt   = '0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    commit    = 1'b0;
    sh_wr     = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == CH_S) state_nxt = S_FIELD;
      end

      S_FIELD: begin
        if (rx_valid) begin
          if (rx_data == CH_W || rx_data == CH_F || rx_data == CH_A || rx_data == CH_P) begin
            if (rx_data == CH_W)      field_nxt = F_W;
            else if (rx_data == CH_F) field_nxt = F_F;
            else if (rx_data == CH_A) field_nxt = F_A;
            else                      field_nxt = F_P;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = S_DIGITS;
          end else if (rx_data != CH_S) begin
            err_nxt   = 1'b1;
            code_nxt  = E_SYNTAX;
            state_nxt = S_IDLE;
          end
        end else if (tmo == TO_LAST) begin
          err_nxt   = 1'b1;
          code_nxt  = E_TIMEOUT;
          state_nxt = S_IDLE;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end

      S_DIGITS: begin
        if (rx_valid) begin
          if (is_digit) begin
            if (cnt == DIG_MAX || acc_dig > field_max) begin
              err_nxt   = 1'b1;
              code_nxt  = E_RANGE;
              state_nxt = S_IDLE;
            end else begin
              acc_nxt = acc_dig;
              cnt_nxt = cnt + 1'b1;
            end
          end else if (rx_data == CH_SEMI) begin
            if (cnt == '0) begin
              err_nxt   = 1'b1;
              code_nxt  = E_SYNTAX;
              state_nxt = S_IDLE;
            end else if (field == F_F && acc == '0) begin
              err_nxt   = 1'b1;
              code_nxt  = E_RANGE;
              state_nxt = S_IDLE;
            end else begin
              sh_wr     = 1'b1;
              state_nxt = SYNC_APPLY ? S_PENDING : S_APPLY;
            end
          end else if (rx_data == CH_S) begin
            state_nxt = S_FIELD;
          end else begin
            err_nxt   = 1'b1;
            code_nxt  = E_SYNTAX;
            state_nxt = S_IDLE;
          end
        end else if (tmo == TO_LAST) begin
          err_nxt   = 1'b1;
          code_nxt  = E_TIMEOUT;
          state_nxt = S_IDLE;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end

      S_PENDING: begin
        if (phase_wrap) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
        if (rx_valid) begin
          err_nxt  = 1'b1;
          code_nxt = E_BUSY;
        end
      end

      S_APPLY: begin
        commit    = 1'b1;
        state_nxt = S_IDLE;
        if (rx_valid) begin
          err_nxt  = 1'b1;
          code_nxt = E_BUSY;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Parser datapath, error flags, shadow and live configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field      <= F_W;
      acc        <= '0;
      cnt        <= '0;
      tmo        <= '0;
      err        <= 1'b0;
      err_code   <= E_SYNTAX;
      cfg_update <= 1'b0;
      sh_wave    <= '0;
      sh_freq    <= 12'd1;
      sh_amp     <= '1;
      sh_phase   <= '0;
      wave_sel   <= '0;
      freq_word  <= 12'd1;
      amp        <= '1;
      phase_off  <= '0;
    end else begin
      field      <= field_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      tmo        <= tmo_nxt;
      err        <= err_nxt;
      err_code   <= code_nxt;
      cfg_update <= commit;
      if (sh_wr) begin
        case (field)
          F_W:     sh_wave  <= acc[2:0];
          F_F:     sh_freq  <= acc[11:0];
          F_A:     sh_amp   <= acc[3:0];
          F_P:     sh_phase <= acc[7:0];
          default: ;
        endcase
      end
      if (commit) begin
        wave_sel  <= sh_wave;
        freq_word <= sh_freq;
        amp       <= sh_amp;
        phase_off <= sh_phase;
      end
    end
  end

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Directed bench for awg_cmd_ctrl: a table of per-cycle input/expected-output
// records plus hand-written sequences for timeout, busy-drop and reset abort.
module tb_awg_cmd_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        phase_wrap;
  logic [2:0]  wave_sel;
  logic [11:0] freq_word;
  logic [3:0]  amp;
  logic [7:0]  phase_off;
  logic        cfg_update;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  awg_cmd_ctrl #(
    .WAVE_NUM   (5),
    .FREQ_MAX   (4095),
    .MAX_DIGITS (4),
    .TIMEOUT    (40),
    .SYNC_APPLY (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .phase_wrap (phase_wrap),
    .wave_sel   (wave_sel),
    .freq_word  (freq_word),
    .amp        (amp),
    .phase_off  (phase_off),
    .cfg_update (cfg_update),
    .busy       (busy),
    .err        (err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        pw;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  // Packed expected outputs: {wave, freq, amp, phase, cfg_update, busy, err, err_code}
  function automatic logic [31:0] ex(input int w, input int f, input int a, input int p,
                                     input bit cu, input bit bz, input bit er, input int ec);
    ex = {3'(w), 12'(f), 4'(a), 8'(p), cu, bz, er, 2'(ec)};
  endfunction

  function automatic void add(input logic v, input logic [7:0] d, input logic pw,
                              input logic [31:0] e);
    vec_t r;
    r.v = v; r.d = d; r.pw = pw; r.exp = e;
    tbl.push_back(r);
  endfunction

  function automatic void add_str(input string s, input logic [31:0] e);
    for (int i = 0; i < s.len(); i++) add(1'b1, s[i], 1'b0, e);
  endfunction

  function automatic void add_idle(input int n, input logic [31:0] e);
    for (int i = 0; i < n; i++) add(1'b0, 8'h00, 1'b0, e);
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic pw);
    rx_valid   = v;
    rx_data    = d;
    phase_wrap = pw;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] e);
    logic [31:0] got;
    got = {wave_sel, freq_word, amp, phase_off, cfg_update, busy, err, err_code};
    n_vec++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got w=%0d f=%0d a=%0d p=%0d cu=%b busy=%b err=%b code=%0d, need w=%0d f=%0d a=%0d p=%0d cu=%b busy=%b err=%b code=%0d",
               name, got[31:29], got[28:17], got[16:13], got[12:5], got[4], got[3], got[2], got[1:0],
               e[31:29], e[28:17], e[16:13], e[12:5], e[4], e[3], e[2], e[1:0]);
    end
  endtask

  task automatic send_chk(input string s, input string name, input logic [31:0] e);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i], 1'b0);
      check(name, e);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    phase_wrap = 1'b0;

    // SF440; committed on a wrap 20 cycles after the terminator
    add_str("SF440", ex(0,1,15,0,0,0,0,0));
    add(1'b1, 8'h3B, 1'b0, ex(0,1,15,0,0,1,0,0));
    add_idle(19, ex(0,1,15,0,0,1,0,0));
    add(1'b0, 8'h00, 1'b1, ex(0,440,15,0,1,0,0,0));
    add_idle(1, ex(0,440,15,0,0,0,0,0));
    // SA9; then SW7; (range error on '7', trailing ';' ignored)
    add_str("SA9", ex(0,440,15,0,0,0,0,0));
    add(1'b1, 8'h3B, 1'b0, ex(0,440,15,0,0,1,0,0));
    add_idle(1, ex(0,440,15,0,0,1,0,0));
    add(1'b0, 8'h00, 1'b1, ex(0,440,9,0,1,0,0,0));
    add_str("SW", ex(0,440,9,0,0,0,0,0));
    add_str("7", ex(0,440,9,0,0,0,1,1));
    add_str(";x", ex(0,440,9,0,0,0,0,1));
    // SP25S P128; : restart discards 25
    add_str("SP25SP128", ex(0,440,9,0,0,0,0,1));
    add(1'b1, 8'h3B, 1'b0, ex(0,440,9,0,0,1,0,1));
    add(1'b0, 8'h00, 1'b1, ex(0,440,9,128,1,0,0,1));
    add_idle(1, ex(0,440,9,128,0,0,0,1));
    // SFx syntax error, then SF12345; range error on 5th digit
    add_str("SF", ex(0,440,9,128,0,0,0,1));
    add_str("x", ex(0,440,9,128,0,0,1,0));
    add_str("SF1234", ex(0,440,9,128,0,0,0,0));
    add_str("5", ex(0,440,9,128,0,0,1,1));
    add_str("5;", ex(0,440,9,128,0,0,0,1));
    // F=0 range error at ';', empty digits syntax error
    add_str("SF0", ex(0,440,9,128,0,0,0,1));
    add_str(";", ex(0,440,9,128,0,0,1,1));
    add_str("SF", ex(0,440,9,128,0,0,0,1));
    add_str(";", ex(0,440,9,128,0,0,1,0));
    // 4096 exceeds FREQ_MAX on the 4th digit; 4095 accepted
    add_str("SF409", ex(0,440,9,128,0,0,0,0));
    add_str("6", ex(0,440,9,128,0,0,1,1));
    add_str("SF4095", ex(0,440,9,128,0,0,0,1));
    add(1'b1, 8'h3B, 1'b0, ex(0,440,9,128,0,1,0,1));
    add(1'b0, 8'h00, 1'b1, ex(0,4095,9,128,1,0,0,1));
    // W=4 is the largest legal waveform
    add_str("SW4", ex(0,4095,9,128,0,0,0,1));
    add(1'b1, 8'h3B, 1'b0, ex(0,4095,9,128,0,1,0,1));
    add(1'b0, 8'h00, 1'b1, ex(4,4095,9,128,1,0,0,1));
    // 'S' restart inside FIELD, then a syntax error inside DIGITS
    add_str("SSA7", ex(4,4095,9,128,0,0,0,1));
    add(1'b1, 8'h3B, 1'b0, ex(4,4095,9,128,0,1,0,1));
    add(1'b0, 8'h00, 1'b1, ex(4,4095,7,128,1,0,0,1));
    add_str("SA1", ex(4,4095,7,128,0,0,0,1));
    add_str("x", ex(4,4095,7,128,0,0,1,0));
    add_idle(1, ex(4,4095,7,128,0,0,0,0));

    #12;
    check("reset_values", ex(0,1,15,0,0,0,0,0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].pw);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Timeout: TIMEOUT idle cycles after a digit aborts the frame
    send_chk("SF1", "to_frame", ex(4,4095,7,128,0,0,0,0));
    for (int i = 0; i < 39; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check("to_wait", ex(4,4095,7,128,0,0,0,0));
    end
    step(1'b0, 8'h00, 1'b0);
    check("to_err", ex(4,4095,7,128,0,0,1,2));
    step(1'b1, 8'h3B, 1'b0);
    check("to_idle", ex(4,4095,7,128,0,0,0,2));

    // A byte on the expiry cycle is processed and no timeout fires
    send_chk("SF1", "exp_frame", ex(4,4095,7,128,0,0,0,2));
    for (int i = 0; i < 39; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check("exp_wait", ex(4,4095,7,128,0,0,0,2));
    end
    step(1'b1, 8'h32, 1'b0);
    check("exp_byte", ex(4,4095,7,128,0,0,0,2));
    step(1'b1, 8'h3B, 1'b0);
    check("exp_pend", ex(4,4095,7,128,0,1,0,2));
    step(1'b0, 8'h00, 1'b1);
    check("exp_commit", ex(4,12,7,128,1,0,0,2));

    // Byte and wrap together in PENDING: commit plus busy-drop error
    send_chk("SA3", "bd_frame", ex(4,12,7,128,0,0,0,2));
    step(1'b1, 8'h3B, 1'b0);
    check("bd_pend", ex(4,12,7,128,0,1,0,2));
    step(1'b1, 8'h78, 1'b1);
    check("bd_commit", ex(4,12,3,128,1,0,1,3));
    step(1'b0, 8'h00, 1'b0);
    check("bd_after", ex(4,12,3,128,0,0,0,3));

    // Reset asserted mid-PENDING aborts with no commit
    send_chk("SW2", "rst_frame", ex(4,12,3,128,0,0,0,3));
    step(1'b1, 8'h3B, 1'b0);
    check("rst_pend", ex(4,12,3,128,0,1,0,3));
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_async", ex(0,1,15,0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    check("rst_wrap", ex(0,1,15,0,0,0,0,0));
    // Shadows were reset too: only the new amp lands, W=2 is gone
    send_chk("SA5", "rst_shadow_frame", ex(0,1,15,0,0,0,0,0));
    step(1'b1, 8'h3B, 1'b0);
    check("rst_shadow_pend", ex(0,1,15,0,0,1,0,0));
    step(1'b0, 8'h00, 1'b1);
    check("rst_shadow_commit", ex(0,1,5,0,1,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
